// File: rtl/render_pkg.sv
// Shared render-region constants, frame-buffer writer state type and pixel packing helper.
// The renderer, the frame-buffer writer and the read-side address logic all import this package.
package render_pkg;

    localparam int START_X = 390;
    localparam int START_Y = 390;
    localparam int END_X   = 634;
    localparam int END_Y   = 765;
    localparam int WIDTH   = END_X - START_X;
    localparam int HEIGHT  = END_Y - START_Y;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SWAP = 2'd2
    } fbw_state_t;

    // Keep the top nibble of each 8-bit channel: {R[7:4], G[7:4], B[7:4]}.
    function automatic logic [11:0] pack_rgb444(input logic [23:0] rgb);
        return {rgb[23:20], rgb[15:12], rgb[7:4]};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// The count holds at all-ones rather than wrapping back to zero.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         clear_in,
    input  logic         inc_in,
    output logic [W-1:0] count_out
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clear_in) begin
            count_d = '0;
        end else if (inc_in && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/render_fb_writer.sv
// Renderer pixel-stream sink: range-checks, packs to RGB444 and writes the frame buffer through a
// two-stage pipeline, toggling the double-buffer bank at every completed frame.
//
// state | meaning
// IDLE  | waiting for the pixel at (START_X,START_Y); other in-region pixels are dropped
// FILL  | writing every in-region pixel; a start pixel restarts the frame (resync)
// SWAP  | one-cycle bubble after the last pixel, tready held low
module render_fb_writer
    import render_pkg::*;
#(
    parameter int START_X    = render_pkg::START_X,
    parameter int START_Y    = render_pkg::START_Y,
    parameter int END_X      = render_pkg::END_X,
    parameter int END_Y      = render_pkg::END_Y,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [23:0]           pixel_axis_tdata,
    input  logic                  pixel_axis_tvalid,
    output logic                  pixel_axis_tready,
    input  logic [10:0]           hcount_in,
    input  logic [9:0]            vcount_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [11:0]           data_out,
    output logic                  we_out,
    output logic                  buf_sel_out,
    output logic                  frame_done_out,
    output logic [ADDR_WIDTH-1:0] frame_pixels_out,
    output logic [15:0]           oob_count_out,
    output logic [15:0]           resync_count_out
);

    localparam int FB_W = END_X - START_X;

    localparam logic [10:0] SX = 11'(START_X);
    localparam logic [10:0] EX = 11'(END_X);
    localparam logic [10:0] LX = 11'(END_X - 1);
    localparam logic [9:0]  SY = 10'(START_Y);
    localparam logic [9:0]  EY = 10'(END_Y);
    localparam logic [9:0]  LY = 10'(END_Y - 1);

    fbw_state_t state_d, state_q;

    logic accept;
    logic in_region;
    logic is_start;
    logic is_end;
    logic oob_inc;
    logic resync_inc;

    logic                  s1_valid_d, s1_valid_q;
    logic                  s1_last_d,  s1_last_q;
    logic [10:0]           s1_x_d,     s1_x_q;
    logic [9:0]            s1_y_d,     s1_y_q;
    logic [11:0]           s1_data_d,  s1_data_q;
    logic [ADDR_WIDTH-1:0] cnt_d,      cnt_q;

    logic [ADDR_WIDTH-1:0] addr_d,         addr_q;
    logic [11:0]           data_d,         data_q;
    logic                  we_d,           we_q;
    logic                  done_d,         done_q;
    logic                  buf_sel_d,      buf_sel_q;
    logic [ADDR_WIDTH-1:0] frame_pixels_d, frame_pixels_q;

    // Only the top nibble of each channel reaches the buffer.
    logic unused_tdata_lsbs;
    assign unused_tdata_lsbs = ^{pixel_axis_tdata[19:16], pixel_axis_tdata[11:8],
                                 pixel_axis_tdata[3:0]};

    assign pixel_axis_tready = (state_q != SWAP);
    assign accept            = pixel_axis_tvalid && pixel_axis_tready;

    assign in_region = (hcount_in >= SX) && (hcount_in < EX) &&
                       (vcount_in >= SY) && (vcount_in < EY);
    assign is_start  = (hcount_in == SX) && (vcount_in == SY);
    assign is_end    = (hcount_in == LX) && (vcount_in == LY);

    // Stage 1: acceptance, frame tracking and offset capture.
    always_comb begin
        state_d    = state_q;
        s1_valid_d = 1'b0;
        s1_last_d  = 1'b0;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_data_d  = s1_data_q;
        cnt_d      = cnt_q;
        oob_inc    = 1'b0;
        resync_inc = 1'b0;

        if (accept) begin
            s1_x_d    = hcount_in - SX;
            s1_y_d    = vcount_in - SY;
            s1_data_d = pack_rgb444(pixel_axis_tdata);
            oob_inc   = !in_region;
        end

        unique case (state_q)
            IDLE: begin
                if (accept && in_region && is_start) begin
                    s1_valid_d = 1'b1;
                    cnt_d      = ADDR_WIDTH'(1);
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (accept && in_region) begin
                    s1_valid_d = 1'b1;
                    if (is_start) begin
                        resync_inc = 1'b1;
                        cnt_d      = ADDR_WIDTH'(1);
                    end else begin
                        cnt_d = cnt_q + ADDR_WIDTH'(1);
                        if (is_end) begin
                            s1_last_d = 1'b1;
                            state_d   = SWAP;
                        end
                    end
                end
            end
            SWAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stage 2: address multiply and registered write. cnt_q already includes the last pixel here
    // because nothing is accepted during the SWAP cycle.
    always_comb begin
        addr_d         = addr_q;
        data_d         = data_q;
        we_d           = s1_valid_q;
        done_d         = s1_last_q;
        buf_sel_d      = buf_sel_q ^ s1_last_q;
        frame_pixels_d = s1_last_q ? cnt_q : frame_pixels_q;
        if (s1_valid_q) begin
            addr_d = ADDR_WIDTH'(s1_x_q) + ADDR_WIDTH'(s1_y_q) * ADDR_WIDTH'(FB_W);
            data_d = s1_data_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= IDLE;
            s1_valid_q     <= 1'b0;
            s1_last_q      <= 1'b0;
            s1_x_q         <= '0;
            s1_y_q         <= '0;
            s1_data_q      <= '0;
            cnt_q          <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            we_q           <= 1'b0;
            done_q         <= 1'b0;
            buf_sel_q      <= 1'b0;
            frame_pixels_q <= '0;
        end else begin
            state_q        <= state_d;
            s1_valid_q     <= s1_valid_d;
            s1_last_q      <= s1_last_d;
            s1_x_q         <= s1_x_d;
            s1_y_q         <= s1_y_d;
            s1_data_q      <= s1_data_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            we_q           <= we_d;
            done_q         <= done_d;
            buf_sel_q      <= buf_sel_d;
            frame_pixels_q <= frame_pixels_d;
        end
    end

    sat_counter #(.W(16)) u_oob_cnt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear_in  (1'b0),
        .inc_in    (oob_inc),
        .count_out (oob_count_out)
    );

    sat_counter #(.W(16)) u_resync_cnt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear_in  (1'b0),
        .inc_in    (resync_inc),
        .count_out (resync_count_out)
    );

    assign addr_out         = addr_q;
    assign data_out         = data_q;
    assign we_out           = we_q;
    assign frame_done_out   = done_q;
    assign buf_sel_out      = buf_sel_q;
    assign frame_pixels_out = frame_pixels_q;

endmodule
